frame14x14_packer: RTL and testbench

- Writer side of the 14x14 pooling stage.
- Accepts an 8-bit pixel stream in row-major order over a valid/ready handshake.
- Assembles the pixels into a flattened 14x14 frame register, then presents that frame to the 2x2 max-pool reader together with a frame_valid/frame_ack handshake.
- Sits between the conv/activation output stream and the 14x14 max-pool block.

---
 rtl/frame14x14_pkg.sv | 13 +
 rtl/frame14x14_bank.sv | 20 ++
 rtl/frame14x14_packer.sv | 94 +++++++++
 tb/tb_frame14x14_packer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/frame14x14_pkg.sv
// frame14x14_pkg: shared frame geometry, packer state type and pixel slot addressing
package frame14x14_pkg;
  localparam int PIX_W = 8;
  localparam int ROWS = 14;
  localparam int COLS = 14;
  localparam int NPIX = ROWS * COLS;
  localparam int FRAME_W = NPIX * PIX_W;
  localparam int IDX_W = $clog2(NPIX);
  typedef enum logic {FILL, HOLD} state_t;
  function automatic int pix_lsb(input logic [IDX_W-1:0] idx);
    return int'(idx) * PIX_W;
  endfunction
endpackage

// File: rtl/frame14x14_bank.sv
// frame14x14_bank: one 14x14 pixel register array with indexed write and flattened read
module frame14x14_bank
  import frame14x14_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [IDX_W-1:0]   idx,
  input  logic [PIX_W-1:0]   pix,
  output logic [FRAME_W-1:0] data
);
  logic [PIX_W-1:0] mem [NPIX];
  // slot write; reset clears the array so the published frame is deterministic
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < NPIX; i++) mem[i] <= '0;
    else if (we) mem[idx] <= pix;
  for (genvar g = 0; g < NPIX; g++) begin : g_flat
    assign data[pix_lsb(IDX_W'(g)) +: PIX_W] = mem[g];
  end
endmodule

// File: rtl/frame14x14_packer.sv
// frame14x14_packer: packs a row-major pixel stream into a 14x14 frame for the max-pool reader (FRAME14X14_PINGPONG_EN adds a second bank)
module frame14x14_packer
  import frame14x14_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pix,
  input  logic               in_last,
  output logic [FRAME_W-1:0] frame_data,
  output logic               frame_valid,
  input  logic               frame_ack,
  output logic               err_len
);
  logic [IDX_W-1:0] idx, idx_n;
  logic xfer, at_end, done;
  assign xfer = in_valid && in_ready;
  assign at_end = idx == IDX_W'(NPIX - 1);
  assign done = xfer && at_end;
  assign idx_n = xfer ? ((at_end || in_last) ? '0 : idx + 1'b1) : idx;
  // write-slot counter and length check; a short frame or a missing in_last both flag err_len
  always_ff @(posedge clk)
    if (rst) begin
      idx <= '0;
      err_len <= 1'b0;
    end else begin
      idx <= idx_n;
      err_len <= xfer && (at_end != in_last);
    end
`ifdef FRAME14X14_PINGPONG_EN
  logic wb, rb, wb_n, rb_n, rel;
  logic [1:0] full, full_n;
  logic [FRAME_W-1:0] bank_data [2];
  assign rel = frame_ack && full[rb];
  assign wb_n = wb ^ done;
  assign rb_n = rb ^ rel;
  // a bank never completes and is released in the same cycle, so both updates are independent
  always_comb begin
    full_n = full;
    if (done) full_n[wb] = 1'b1;
    if (rel) full_n[rb] = 1'b0;
  end
  // writer and reader pointers alternate, which keeps frames in arrival order
  always_ff @(posedge clk)
    if (rst) begin
      wb <= 1'b0;
      rb <= 1'b0;
      full <= '0;
      in_ready <= 1'b1;
    end else begin
      wb <= wb_n;
      rb <= rb_n;
      full <= full_n;
      in_ready <= !full_n[wb_n];
    end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame14x14_bank u_bank (
      .clk  (clk),
      .rst  (rst),
      .we   (xfer && (wb == 1'(b))),
      .idx  (idx),
      .pix  (in_pix),
      .data (bank_data[b])
    );
  end
  assign frame_data = bank_data[rb];
  assign frame_valid = full[rb];
`else
  state_t state, state_n;
  // FILL until the 196th pixel lands, HOLD until the reader acknowledges
  always_comb begin
    state_n = (state == FILL) ? (done ? HOLD : FILL) : (frame_ack ? FILL : HOLD);
  end
  // state register; in_ready is registered from the next state so it never lags the FSM
  always_ff @(posedge clk)
    if (rst) begin
      state <= FILL;
      in_ready <= 1'b1;
    end else begin
      state <= state_n;
      in_ready <= state_n == FILL;
    end
  frame14x14_bank u_bank (
    .clk  (clk),
    .rst  (rst),
    .we   (xfer),
    .idx  (idx),
    .pix  (in_pix),
    .data (frame_data)
  );
  assign frame_valid = state == HOLD;
`endif
endmodule

// File: tb/tb_frame14x14_packer.sv
// tb_frame14x14_packer: directed self-checking bench for the 14x14 frame packer
module tb_frame14x14_packer;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, frame_ack = 0;
  logic [7:0] in_pix = 0;
  logic in_ready, frame_valid, err_len;
  logic [1567:0] frame_data;
  logic fv_before;
  int n_tests = 0, n_fail = 0;
  frame14x14_packer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .in_last(in_last), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ack(frame_ack), .err_len(err_len)
  );
  always #5 clk = ~clk;
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_frame(input string tag, input int off);
    int bad = 0;
    for (int i = 0; i < 196; i++) if (frame_data[i*8 +: 8] !== 8'(i + off)) bad++;
    check(tag, bad, 0);
  endtask
  task automatic send_frame(input int n, input int last_at, input int off, output int stalls);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1;
      in_pix = 8'(i + off);
      in_last = (i == last_at);
      while (!in_ready && stalls < 2000) begin
        tick();
        stalls++;
      end
      if (i == n - 1) fv_before = frame_valid;
      tick();
    end
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic ack();
    frame_ack = 1;
    tick();
    frame_ack = 0;
  endtask
`ifdef FRAME14X14_PINGPONG_EN
  int s1, s2, s3;
  int seen [3];
`endif
  initial begin
    int s;
    tick();
    tick();
    rst = 0;
    check("rst_ready", in_ready, 1);
    check("rst_valid", frame_valid, 0);
    check("rst_err", err_len, 0);
    check("rst_data", |frame_data, 0);
`ifdef FRAME14X14_PINGPONG_EN
    fork
      begin
        send_frame(196, 195, 1, s1);
        send_frame(196, 195, 2, s2);
        send_frame(196, 195, 3, s3);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          int w = 0;
          while (!frame_valid && w < 3000) begin
            tick();
            w++;
          end
          seen[k] = int'(frame_data[7:0]);
          check_frame($sformatf("pp_frame%0d", k + 1), k + 1);
          repeat (300) tick();
          ack();
        end
      end
    join
    check("pp_stall1", s1, 0);
    check("pp_stall2", s2, 0);
    check("pp_stall3", (s3 > 0) && (s3 < 2000), 1);
    for (int k = 0; k < 3; k++) check($sformatf("pp_order%0d", k + 1), seen[k], k + 1);
    check("pp_empty", frame_valid, 0);
    check("pp_ready", in_ready, 1);
`else
    send_frame(196, 195, 0, s);
    check("f1_stall", s, 0);
    check("f1_valid_before", fv_before, 0);
    check("f1_valid", frame_valid, 1);
    check("f1_err", err_len, 0);
    check("f1_ready", in_ready, 0);
    check("f1_pix0", frame_data[7:0], 0);
    check("f1_pix14", frame_data[119:112], 14);
    check("f1_pix195", frame_data[1567:1560], 195);
    check_frame("f1_frame", 0);
    in_valid = 1;
    in_pix = 8'hAA;
    repeat (10) tick();
    in_valid = 0;
    check("hold_ready", in_ready, 0);
    check("hold_valid", frame_valid, 1);
    check_frame("hold_frame", 0);
    ack();
    check("ack_valid", frame_valid, 0);
    check("ack_ready", in_ready, 1);
    ack();
    check("idle_ack_valid", frame_valid, 0);
    check("idle_ack_ready", in_ready, 1);
    send_frame(100, 99, 0, s);
    check("short_err", err_len, 1);
    check("short_valid", frame_valid, 0);
    check("short_ready", in_ready, 1);
    tick();
    check("short_err_pulse", err_len, 0);
    send_frame(196, 195, 7, s);
    check("f2_valid", frame_valid, 1);
    check("f2_err", err_len, 0);
    check("f2_pix0", frame_data[7:0], 7);
    check("f2_pix195", frame_data[1567:1560], 202);
    check_frame("f2_frame", 7);
    ack();
    send_frame(196, -1, 3, s);
    check("nolast_valid", frame_valid, 1);
    check("nolast_err", err_len, 1);
    check_frame("nolast_frame", 3);
    tick();
    check("nolast_err_pulse", err_len, 0);
    ack();
    send_frame(50, -1, 0, s);
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_valid", frame_valid, 0);
    check("mid_rst_data", |frame_data, 0);
    send_frame(196, 195, 9, s);
    check("f3_valid", frame_valid, 1);
    check_frame("f3_frame", 9);
    rst = 1;
    tick();
    rst = 0;
    check("hold_rst_ready", in_ready, 1);
    check("hold_rst_valid", frame_valid, 0);
    check("hold_rst_err", err_len, 0);
    check("hold_rst_data", |frame_data, 0);
    send_frame(196, 195, 5, s);
    check("f4_valid", frame_valid, 1);
    check("f4_pix0", frame_data[7:0], 5);
    check_frame("f4_frame", 5);
    ack();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
